// File: rtl/frame_serializer.sv
// frame_serializer
//   Sends one serial frame per accepted request: a start bit, the code field
//   c (MSB first), the data field b (MSB first), a parity bit, then NSTOP stop
//   bits at level ~cod. One bit per clk cycle. c, b, bp and cod are captured
//   on the edge that accepts the request, so the frame is not affected by
//   later input changes.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line low, waiting for hab
//   S_START  | start bit (1) on o
//   S_CFIELD | code field bits on o, r_cnt counts remaining bits down
//   S_BFIELD | data field bits on o, r_cnt counts remaining bits down
//   S_PAR    | parity bit on o
//   S_STOP   | stop bits on o, r_cnt counts remaining bits down
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   hab   in   frame request; ignored while a frame is in progress
//   c     in   [CW-1:0] code field
//   b     in   [BW-1:0] data field
//   bp    in   external parity bit (PAR_MODE=0)
//   cod   in   stop-level select, stop bit = ~cod
//   o     out  serial line (registered)
//   busy  out  high while a frame bit is on o (registered)
//   done  out  one-cycle pulse during the last stop bit (registered)

module frame_serializer #(
  parameter int CW       = 4,
  parameter int BW       = 4,
  parameter int NSTOP    = 2,
  parameter int PAR_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hab,
  input  logic [CW-1:0] c,
  input  logic [BW-1:0] b,
  input  logic          bp,
  input  logic          cod,
  output logic          o,
  output logic          busy,
  output logic          done
);

  localparam int MAXN = (CW > BW) ? ((CW > NSTOP) ? CW : NSTOP)
                                  : ((BW > NSTOP) ? BW : NSTOP);
  localparam int CNTW = (MAXN > 1) ? $clog2(MAXN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CFIELD,
    S_BFIELD,
    S_PAR,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_cnt;
  logic [CW-1:0]     r_c;
  logic [BW-1:0]     r_b;
  logic              r_par;
  logic              r_stop;
  logic              r_o;
  logic              r_busy;
  logic              r_done;

  logic              w_xor;
  logic              w_par;
  logic              w_cnt_zero;
  logic              w_start;

  assign w_xor      = ^{c, b};
  assign w_par      = (PAR_MODE == 0) ? bp :
                      (PAR_MODE == 1) ? w_xor : ~w_xor;
  assign w_cnt_zero = (r_cnt == '0);

  // A request is accepted when idle, or on the last stop bit so that the
  // next start bit follows without a gap.
  assign w_start    = hab && ((r_state == S_IDLE) ||
                              ((r_state == S_STOP) && w_cnt_zero));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_c     <= '0;
      r_b     <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      r_o     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        // Parity is resolved at capture time from the same values that are
        // captured, so it always matches the transmitted fields.
        r_c     <= c;
        r_b     <= b;
        r_par   <= w_par;
        r_stop  <= ~cod;
        r_cnt   <= '0;
        r_state <= S_START;
        r_o     <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_o    <= 1'b0;
            r_busy <= 1'b0;
          end
          S_START: begin
            // Fields are shifted left so the next bit is always the MSB.
            r_state <= S_CFIELD;
            r_cnt   <= CNTW'(CW - 1);
            r_o     <= r_c[CW-1];
            r_c     <= r_c << 1;
          end
          S_CFIELD: begin
            if (w_cnt_zero) begin
              r_state <= S_BFIELD;
              r_cnt   <= CNTW'(BW - 1);
              r_o     <= r_b[BW-1];
              r_b     <= r_b << 1;
            end else begin
              r_cnt   <= r_cnt - CNTW'(1);
              r_o     <= r_c[CW-1];
              r_c     <= r_c << 1;
            end
          end
          S_BFIELD: begin
            if (w_cnt_zero) begin
              r_state <= S_PAR;
              r_o     <= r_par;
            end else begin
              r_cnt   <= r_cnt - CNTW'(1);
              r_o     <= r_b[BW-1];
              r_b     <= r_b << 1;
            end
          end
          S_PAR: begin
            r_state <= S_STOP;
            r_cnt   <= CNTW'(NSTOP - 1);
            r_o     <= r_stop;
            r_done  <= (NSTOP == 1);
          end
          S_STOP: begin
            if (w_cnt_zero) begin
              r_state <= S_IDLE;
              r_o     <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= r_cnt - CNTW'(1);
              r_o     <= r_stop;
              r_done  <= (r_cnt == CNTW'(1));
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_o     <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o    = r_o;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: three instances with different configurations
// share the control stimulus. A frame-level model predicts o/busy/done for
// each instance every cycle; directed frames pin the model with literal
// expected bit sequences.

module tb_frame_serializer;

  logic       clk;
  logic       rst;
  logic       hab;
  logic [3:0] c4;
  logic [3:0] b4;
  logic [7:0] c8;
  logic [7:0] b8;
  logic       bp;
  logic       cod;
  logic [2:0] w_o;
  logic [2:0] w_busy;
  logic [2:0] w_done;

  int vectors = 0;
  int errors  = 0;

  frame_serializer #(.CW(4), .BW(4), .NSTOP(2), .PAR_MODE(0)) u_d0 (
    .clk(clk), .rst(rst), .hab(hab), .c(c4), .b(b4), .bp(bp), .cod(cod),
    .o(w_o[0]), .busy(w_busy[0]), .done(w_done[0]));

  frame_serializer #(.CW(4), .BW(4), .NSTOP(2), .PAR_MODE(1)) u_d1 (
    .clk(clk), .rst(rst), .hab(hab), .c(c4), .b(b4), .bp(bp), .cod(cod),
    .o(w_o[1]), .busy(w_busy[1]), .done(w_done[1]));

  frame_serializer #(.CW(8), .BW(8), .NSTOP(1), .PAR_MODE(2)) u_d2 (
    .clk(clk), .rst(rst), .hab(hab), .c(c8), .b(b8), .bp(bp), .cod(cod),
    .o(w_o[2]), .busy(w_busy[2]), .done(w_done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  int cfg_cw [3] = '{4, 4, 8};
  int cfg_bw [3] = '{4, 4, 8};
  int cfg_ns [3] = '{2, 2, 1};
  int cfg_pm [3] = '{0, 1, 2};
  int m_len  [3] = '{12, 12, 19};
  bit m_act  [3];
  int m_pos  [3];
  bit m_fr   [3][32];
  bit started = 1'b0;

  function automatic void build(input int i, input bit [7:0] cv,
                                input bit [7:0] bv, input bit pb, input bit cd);
    int ones;
    bit par;
    m_fr[i][0] = 1'b1;
    for (int j = 0; j < cfg_cw[i]; j++) m_fr[i][1 + j] = cv[cfg_cw[i] - 1 - j];
    for (int j = 0; j < cfg_bw[i]; j++) m_fr[i][1 + cfg_cw[i] + j] = bv[cfg_bw[i] - 1 - j];
    ones = $countones(cv) + $countones(bv);
    if (cfg_pm[i] == 0)      par = pb;
    else if (cfg_pm[i] == 1) par = (ones % 2) == 1;
    else                     par = (ones % 2) == 0;
    m_fr[i][1 + cfg_cw[i] + cfg_bw[i]] = par;
    for (int j = 0; j < cfg_ns[i]; j++) m_fr[i][2 + cfg_cw[i] + cfg_bw[i] + j] = !cd;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_pos[i] = 0;
      end else if (!m_act[i] || m_pos[i] == m_len[i] - 1) begin
        if (hab) begin
          if (i == 2) build(i, c8, b8, bp, cod);
          else        build(i, {4'b0, c4}, {4'b0, b4}, bp, cod);
          m_pos[i] = 0;
          m_act[i] = 1'b1;
        end else begin
          m_act[i] = 1'b0;
        end
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        logic [2:0] e;
        e[2] = m_act[i] ? m_fr[i][m_pos[i]] : 1'b0;
        e[1] = m_act[i];
        e[0] = m_act[i] && (m_pos[i] == m_len[i] - 1);
        chk($sformatf("model_d%0d_o_busy_done", i),
            {29'b0, w_o[i], w_busy[i], w_done[i]}, {29'b0, e});
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic so [3][40];
  logic sb [3][40];
  logic sd [3][40];

  task automatic snap(input int t);
    for (int i = 0; i < 3; i++) begin
      so[i][t] = w_o[i];
      sb[i][t] = w_busy[i];
      sd[i][t] = w_done[i];
    end
  endtask

  // Caller raises hab at a negedge; sample t shows frame bit t.
  task automatic cap(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t == 0) hab = 1'b0;
      snap(t);
    end
  endtask

  task automatic idle(input int n);
    hab = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [11:0] exp31;
    rst = 1'b1; hab = 1'b1; c4 = 4'hF; b4 = 4'hF; c8 = 8'hFF; b8 = 8'hFF;
    bp = 1'b1; cod = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_d%0d", i), {29'b0, w_o[i], w_busy[i], w_done[i]}, 32'd0);
    rst = 1'b0;
    idle(3);

    // Default frame, bp=1, cod=0; also parity of the internal-parity instances.
    exp31 = 12'b1101_0001_1111;
    c4 = 4'b1010; b4 = 4'b0011; c8 = 8'h0A; b8 = 8'h03; bp = 1'b1; cod = 1'b0;
    hab = 1'b1;
    cap(20);
    for (int t = 0; t < 13; t++) begin
      logic [11:0] tmp;
      tmp = exp31;
      chk($sformatf("basic_o_bit%0d", t), {31'b0, so[0][t]}, (t < 12) ? {31'b0, tmp[11 - t]} : 32'd0);
      chk($sformatf("basic_done_%0d", t), {31'b0, sd[0][t]}, (t == 11) ? 32'd1 : 32'd0);
      chk($sformatf("basic_busy_%0d", t), {31'b0, sb[0][t]}, (t < 12) ? 32'd1 : 32'd0);
    end
    chk("even_par_1010_0011", {31'b0, so[1][9]}, 32'd0);
    chk("odd_par_1010_0011", {31'b0, so[2][17]}, 32'd1);
    idle(5);

    c4 = 4'b1000; b4 = 4'b0000; hab = 1'b1;
    cap(14);
    chk("even_par_1000_0000", {31'b0, so[1][9]}, 32'd1);
    idle(20);

    // Back-to-back frames with hab held high.
    c4 = 4'b1111; b4 = 4'b0000; bp = 1'b0; cod = 1'b0; hab = 1'b1;
    for (int t = 0; t < 26; t++) begin
      @(negedge clk);
      snap(t);
      if (t == 11) begin c4 = 4'b0001; b4 = 4'b1000; end
      if (t == 23) hab = 1'b0;
    end
    for (int t = 0; t < 25; t++) begin
      chk($sformatf("b2b_busy_%0d", t), {31'b0, sb[0][t]}, (t < 24) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_done_%0d", t), {31'b0, sd[0][t]}, (t == 11 || t == 23) ? 32'd1 : 32'd0);
    end
    chk("b2b_startB", {31'b0, so[0][12]}, 32'd1);
    chk("b2b_cB", {28'b0, so[0][13], so[0][14], so[0][15], so[0][16]}, 32'b0001);
    chk("b2b_bB", {28'b0, so[0][17], so[0][18], so[0][19], so[0][20]}, 32'b1000);
    idle(20);

    // Mid-frame change of c must not reach the line.
    c4 = 4'b1010; b4 = 4'b0110; hab = 1'b1;
    for (int t = 0; t < 13; t++) begin
      @(negedge clk);
      if (t == 0) hab = 1'b0;
      snap(t);
      if (t == 3) c4 = 4'b0101;
    end
    chk("hold_c_field", {28'b0, so[0][1], so[0][2], so[0][3], so[0][4]}, 32'b1010);
    idle(20);

    // Reset in the middle of a frame.
    c4 = 4'b1111; b4 = 4'b1111; hab = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t == 0) hab = 1'b0;
      snap(t);
      if (t == 6) rst = 1'b1;
      if (t == 7) rst = 1'b0;
    end
    chk("abort_busy_before", {31'b0, sb[0][6]}, 32'd1);
    for (int t = 7; t < 16; t++)
      chk($sformatf("abort_quiet_%0d", t), {29'b0, so[0][t], sb[0][t], sd[0][t]}, 32'd0);
    c4 = 4'b0110; b4 = 4'b1001; hab = 1'b1;
    cap(13);
    chk("abort_restart_start", {30'b0, so[0][0], sb[0][0]}, 32'b11);
    chk("abort_restart_done", {31'b0, sd[0][11]}, 32'd1);
    idle(20);

    // Wide instance, one stop bit at cod=1.
    cod = 1'b1; c8 = 8'h5C; b8 = 8'hA3; hab = 1'b1;
    cap(21);
    chk("wide_start", {31'b0, so[2][0]}, 32'd1);
    chk("wide_stop", {31'b0, so[2][18]}, 32'd0);
    chk("wide_done19", {31'b0, sd[2][18]}, 32'd1);
    chk("wide_done18", {31'b0, sd[2][17]}, 32'd0);
    chk("wide_busy19", {30'b0, sb[2][18], sb[2][19]}, 32'b10);
    idle(20);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      hab = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) < 3);
      c4  = 4'($urandom);
      b4  = 4'($urandom);
      c8  = 8'($urandom);
      b8  = 8'($urandom);
      bp  = 1'($urandom);
      cod = 1'($urandom);
    end
    rst = 1'b0;
    idle(25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
